matrix_feeder: RTL and testbench

- Front-end sequencer for the 3x3 determinant datapath.
- Accepts matrix elements one at a time over a valid/ready stream in row-major order, E[0][0] first and E[2][2] last.
- Packs them into the 45-bit packed-matrix word that the determinant block consumes, and holds that word stable while the block computes.
- After a fixed settle delay, captures the returned 16-bit determinant and presents it on a valid/ready result port.

---
 rtl/matrix_feeder.sv | 152 +++++++++++++++
 tb/tb_matrix_feeder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// matrix_feeder: collects nine elements in row-major order into the packed
// matrix word, holds it while the determinant block settles, then captures the
// returned determinant and offers it on a valid/ready result port.
module matrix_feeder #(
  parameter int ELEM_W      = 5,
  parameter int DET_W       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ELEM_W-1:0]     elem_in,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  output logic [3:0]            elem_count,
  output logic [9*ELEM_W-1:0]   matrix_out,
  input  logic [DET_W-1:0]      det_in,
  output logic [DET_W-1:0]      res_data,
  output logic                  res_neg,
  output logic                  res_valid,
  input  logic                  res_ready
);

  localparam int MAT_W = 9 * ELEM_W;
  localparam int WCW   = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [MAT_W-1:0]   mat_q;
  logic [DET_W-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic               rv_q, rv_d;

  logic               load_en;
  logic               wait_hit;
  logic [8:0]         slot_we;

  // An element is taken only while loading; flush drops a coincident transfer.
  assign load_en  = (state_q == S_LOAD) && elem_valid && !flush;
  assign wait_hit = (state_q == S_WAIT) && (wcnt_q == WCW'(WAIT_CYCLES));

  // One write strobe per matrix slot, selected by the running element index.
  for (genvar gi = 0; gi < 9; gi++) begin : g_slot_we
    assign slot_we[gi] = load_en && (count_q == 4'(gi));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic: flush aborts to LOAD from anywhere.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (elem_valid && count_q == 4'd8) state_d = S_WAIT;
        S_WAIT:  if (wait_hit) state_d = S_DONE;
        S_DONE:  if (res_ready) state_d = S_LOAD;
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    elem_ready = (state_q == S_LOAD);
  end

  // Counter and result next-state values.
  always_comb begin
    count_d = count_q;
    wcnt_d  = wcnt_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rv_d    = rv_q;
    if (flush) begin
      count_d = 4'd0;
      wcnt_d  = '0;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (elem_valid) begin
            count_d = count_q + 4'd1;
            wcnt_d  = '0;
          end
        end
        S_WAIT: begin
          wcnt_d = wcnt_q + 1'b1;
          if (wait_hit) begin
            res_d = det_in;
            neg_d = det_in[DET_W-1];
            rv_d  = 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            rv_d    = 1'b0;
            count_d = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Counter and result registers; matrix and result survive a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
      wcnt_q  <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rv_q    <= rv_d;
    end
  end

  // Matrix word: element i lands at the i-th field counted from the MSB end.
  always_ff @(posedge clk) begin
    if (reset) begin
      mat_q <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (slot_we[i]) mat_q[MAT_W-1-ELEM_W*i -: ELEM_W] <= elem_in;
      end
    end
  end

  assign elem_count = count_q;
  assign matrix_out = mat_q;
  assign res_data   = res_q;
  assign res_neg    = neg_q;
  assign res_valid  = rv_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Bench for matrix_feeder: table of known matrices plus random matrices,
// with a behavioural determinant block attached behind a two-stage delay.
module tb_matrix_feeder;

  logic        clk = 1'b0;
  logic        reset, flush, elem_valid, res_ready;
  logic [4:0]  elem_in;
  logic        elem_ready, res_neg, res_valid;
  logic [3:0]  elem_count;
  logic [44:0] matrix_out;
  logic [15:0] det_in, res_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_feeder #(.ELEM_W(5), .DET_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_count(elem_count), .matrix_out(matrix_out), .det_in(det_in),
    .res_data(res_data), .res_neg(res_neg), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // Stand-in determinant block: cofactor expansion of the packed word.
  function automatic logic [15:0] det_of(input logic [44:0] m);
    int e[9];
    int d;
    for (int i = 0; i < 9; i++) e[i] = int'(m[44-5*i -: 5]);
    d = e[0]*(e[4]*e[8]-e[5]*e[7]) - e[1]*(e[3]*e[8]-e[5]*e[6]) + e[2]*(e[3]*e[7]-e[4]*e[6]);
    return 16'(d);
  endfunction

  logic [15:0] dp1 = 16'd0, dp2 = 16'd0;
  always @(posedge clk) begin
    dp1 <= det_of(matrix_out);
    dp2 <= dp1;
  end
  assign det_in = dp2;

  // Reference determinant from the element list (rule of Sarrus).
  function automatic logic [15:0] ref_det(input logic [8:0][4:0] a);
    int e[9];
    int d;
    for (int i = 0; i < 9; i++) e[i] = int'(a[i]);
    d = e[0]*e[4]*e[8] + e[1]*e[5]*e[6] + e[2]*e[3]*e[7]
      - e[2]*e[4]*e[6] - e[0]*e[5]*e[7] - e[1]*e[3]*e[8];
    return 16'(d);
  endfunction

  function automatic logic [8:0][4:0] m9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [8:0][4:0] r;
    r[0] = 5'(e0); r[1] = 5'(e1); r[2] = 5'(e2);
    r[3] = 5'(e3); r[4] = 5'(e4); r[5] = 5'(e5);
    r[6] = 5'(e6); r[7] = 5'(e7); r[8] = 5'(e8);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Offer one element until it is accepted; rnd randomises elem_valid.
  task automatic send_elem(input logic [4:0] e, input bit rnd, output int edge_no);
    bit   got;
    logic r;
    got = 1'b0;
    edge_no = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      elem_in    = e;
      elem_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r          = elem_ready;
      @(posedge clk); #1;
      edge_no = cyc;
      if (elem_valid && r) got = 1'b1;
    end
    if (!got) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Full transaction: load, wait for the result, optional stall, handshake.
  task automatic run_matrix(input logic [8:0][4:0] a, input bit rnd, input int hold,
                            input logic [15:0] exp_d, input logic [4:0] next_e,
                            output int k);
    logic [44:0] pk;
    int          lat;
    bit          seen;
    pk = '0;
    res_ready = (hold == 0);
    for (int i = 0; i < 9; i++) begin
      pk[44-5*i -: 5] = a[i];
      send_elem(a[i], rnd, k);
      if (i < 8) chk("count_step", 64'(elem_count), 64'(i + 1));
    end
    // Keep the next element pending across WAIT/DONE.
    elem_in    = next_e;
    elem_valid = 1'b1;
    chk("matrix_out", 64'(matrix_out), 64'(pk));
    chk("count9", 64'(elem_count), 64'd9);
    chk("ready_wait", 64'(elem_ready), 64'd0);
    lat  = 0;
    seen = 1'b0;
    for (int t = 1; t <= 20 && !seen; t++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        seen = 1'b1;
        lat  = t;
      end
    end
    chk("latency", 64'(lat), 64'd3);
    chk("res_data", 64'(res_data), 64'(exp_d));
    chk("res_neg", 64'(res_neg), 64'(exp_d[15]));
    chk("matrix_hold", 64'(matrix_out), 64'(pk));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(exp_d));
      chk("hold_ready", 64'(elem_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 64'(res_valid), 64'd0);
    chk("hs_ready", 64'(elem_ready), 64'd1);
    chk("hs_count", 64'(elem_count), 64'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", 64'(elem_ready), 64'd1);
    chk("rst_count", 64'(elem_count), 64'd0);
    chk("rst_matrix", 64'(matrix_out), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_neg", 64'(res_neg), 64'd0);
  endtask

  typedef struct packed {
    logic [8:0][4:0] a;
    logic [15:0]     det;
    logic            rnd;
    logic [7:0]      hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k, prev_k;
    logic [44:0] pre;
    logic [8:0][4:0] ra;
    logic [4:0]  nx;

    tbl[0] = '{a: m9(1,0,0, 0,1,0, 0,0,1),   det: 16'h0001, rnd: 1'b0, hold: 8'd0};
    tbl[1] = '{a: m9(2,0,0, 0,3,0, 0,0,4),   det: 16'd24,   rnd: 1'b0, hold: 8'd0};
    tbl[2] = '{a: m9(1,2,3, 4,5,6, 7,8,10),  det: 16'hFFFD, rnd: 1'b0, hold: 8'd0};
    tbl[3] = '{a: m9(1,2,3, 4,5,6, 7,8,9),   det: 16'h0000, rnd: 1'b1, hold: 8'd5};
    tbl[4] = '{a: m9(31,0,0, 0,31,0, 0,0,31), det: 16'h745F, rnd: 1'b0, hold: 8'd0};
    tbl[5] = '{a: m9(0,31,0, 31,0,0, 0,0,31), det: 16'h8BA1, rnd: 1'b0, hold: 8'd0};

    reset = 1'b1; flush = 1'b0; elem_valid = 1'b0; res_ready = 1'b0; elem_in = 5'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state();

    // Table-driven matrices, back to back.
    prev_k = 0;
    for (int i = 0; i < 6; i++) begin
      nx = (i < 5) ? tbl[i+1].a[0] : 5'd0;
      run_matrix(tbl[i].a, tbl[i].rnd, int'(tbl[i].hold), tbl[i].det, nx, k);
      if (i > 0 && !tbl[i].rnd && !tbl[i-1].rnd && tbl[i-1].hold == 0)
        chk("period", 64'(k - prev_k), 64'd13);
      prev_k = k;
    end

    // Flush after four elements: partial matrix dropped, coincident transfer dropped.
    for (int i = 0; i < 4; i++) send_elem(5'd9, 1'b0, k);
    pre = matrix_out;
    elem_in = 5'd7; elem_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_count", 64'(elem_count), 64'd0);
    chk("flush_ready", 64'(elem_ready), 64'd1);
    chk("flush_matrix", 64'(matrix_out), 64'(pre));
    chk("flush_valid", 64'(res_valid), 64'd0);
    run_matrix(tbl[1].a, 1'b0, 0, 16'd24, 5'd0, k);

    // Flush during WAIT: no result appears.
    for (int i = 0; i < 9; i++) send_elem(tbl[2].a[i], 1'b0, k);
    elem_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("wflush_ready", 64'(elem_ready), 64'd1);
    chk("wflush_count", 64'(elem_count), 64'd0);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("wflush_novalid", 64'(res_valid), 64'd0);
    end

    // Reset during WAIT.
    for (int i = 0; i < 9; i++) send_elem(tbl[4].a[i], 1'b0, k);
    elem_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk_reset_state();
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk("wrst_novalid", 64'(res_valid), 64'd0);
    end

    // Random matrices against the reference determinant.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 9; i++) ra[i] = 5'($urandom_range(0, 31));
      run_matrix(ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ref_det(ra), 5'($urandom_range(0, 31)), k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
